// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 device-to-host receiver with E0/F0 prefix tracking and per-key held state.
// Optional macro PS2_GLITCH_FILTER_EN: kb_clk accepted only after 8 consecutive equal samples.
`default_nettype none

module ps2_key_decoder #(
  parameter int                    NUM_KEYS    = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES   = {9'h172, 9'h175, 9'h01B, 9'h01D},
  parameter int                    TIMEOUT_CYC = 100000
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic                kb_clk,
  input  logic                kb_data,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [7:0]          code,
  output logic                code_ext,
  output logic                code_brk,
  output logic                code_valid,
  output logic                frame_err
);

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // PS/2 lines idle high, so synchronisers reset to 1 to avoid a false edge.
  logic [1:0] kbc_sync_q;
  logic [1:0] kbd_sync_q;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      kbc_sync_q <= 2'b11;
      kbd_sync_q <= 2'b11;
    end else begin
      kbc_sync_q <= {kbc_sync_q[0], kb_clk};
      kbd_sync_q <= {kbd_sync_q[0], kb_data};
    end
  end

  logic kbc_lvl;

`ifdef PS2_GLITCH_FILTER_EN
  logic       kbc_filt_q;
  logic [2:0] filt_cnt_q;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      kbc_filt_q <= 1'b1;
      filt_cnt_q <= 3'd0;
    end else if (kbc_sync_q[1] == kbc_filt_q) begin
      filt_cnt_q <= 3'd0;
    end else if (filt_cnt_q == 3'd7) begin
      kbc_filt_q <= kbc_sync_q[1];
      filt_cnt_q <= 3'd0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 3'd1;
    end
  end

  assign kbc_lvl = kbc_filt_q;
`else
  assign kbc_lvl = kbc_sync_q[1];
`endif

  logic kbc_prev_q;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) kbc_prev_q <= 1'b1;
    else        kbc_prev_q <= kbc_lvl;
  end

  logic kbc_fall;
  logic din;
  assign kbc_fall = kbc_prev_q & ~kbc_lvl;
  assign din      = kbd_sync_q[1];

  state_t              state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic                par_q;
  logic                ext_q;
  logic                brk_q;
  logic [TW-1:0]       to_cnt_q;
  logic [NUM_KEYS-1:0] key_state_q;
  logic [NUM_KEYS-1:0] key_state_d;
  logic [7:0]          code_q;
  logic                code_ext_q;
  logic                code_brk_q;
  logic                code_valid_q;
  logic                frame_err_q;

  logic frame_ok;
  logic to_hit;
  assign frame_ok = din & (^{shift_q, par_q});
  assign to_hit   = (state_q != S_IDLE) && !kbc_fall && (to_cnt_q == TO_LAST);

  // Ext flag is part of the match, so a plain byte never hits an E0-prefixed entry.
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEY_CODES[9*i +: 9] == {ext_q, shift_q}) key_state_d[i] = ~brk_q;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      to_cnt_q     <= '0;
      key_state_q  <= '0;
      code_q       <= 8'd0;
      code_ext_q   <= 1'b0;
      code_brk_q   <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (state_q == S_IDLE || kbc_fall || to_hit) to_cnt_q <= '0;
      else                                         to_cnt_q <= to_cnt_q + TW'(1);

      if (to_hit) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end else if (kbc_fall) begin
        case (state_q)
          S_IDLE: begin
            if (!din) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          S_DATA: begin
            shift_q   <= {din, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= din;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!frame_ok) begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              code_q       <= shift_q;
              code_ext_q   <= ext_q;
              code_brk_q   <= brk_q;
              code_valid_q <= 1'b1;
              key_state_q  <= key_state_d;
              ext_q        <= 1'b0;
              brk_q        <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign key_state  = key_state_q;
  assign code       = code_q;
  assign code_ext   = code_ext_q;
  assign code_brk   = code_brk_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: frame-level stimulus for ps2_key_decoder with a queued expected-event scoreboard.
// PS/2 bit timing and TIMEOUT_CYC are scaled down so the run stays short.
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_key_decoder;

  localparam int  TO   = 400;
  localparam time HALF = 400;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       kb_clk  = 1'b1;
  logic       kb_data = 1'b1;
  logic [3:0] key_state;
  logic [7:0] code;
  logic       code_ext;
  logic       code_brk;
  logic       code_valid;
  logic       frame_err;

  ps2_key_decoder #(
    .NUM_KEYS   (4),
    .KEY_CODES  ({9'h172, 9'h175, 9'h01B, 9'h01D}),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50MHz (clk),
    .reset     (rst_n),
    .kb_clk    (kb_clk),
    .kb_data   (kb_data),
    .key_state (key_state),
    .code      (code),
    .code_ext  (code_ext),
    .code_brk  (code_brk),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] ks;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  fails  = 0;
  int  cyc    = 0;
  int  last_fall_cyc = 0;
  bit  glitch_en = 1'b0;

  logic [8:0] keys [4] = '{9'h01D, 9'h01B, 9'h175, 9'h172};
  logic       m_ext = 1'b0, m_brk = 1'b0, m_cext = 1'b0, m_cbrk = 1'b0;
  logic [3:0] m_ks = 4'd0;
  logic [7:0] m_code = 8'd0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && (code_valid || frame_err))
      obs_q.push_back({frame_err, code, code_ext, code_brk, key_state});
  end

  task automatic drive_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kb_data = bits[i];
      #(HALF/2);
      kb_clk = 1'b0;
      last_fall_cyc = cyc;
      #HALF;
      kb_clk = 1'b1;
      if (glitch_en && i == 3) begin
        #(HALF/4); kb_clk = 1'b0; #60; kb_clk = 1'b1; #(HALF/4 - 60);
      end else begin
        #(HALF/2);
      end
    end
    kb_data = 1'b1;
  endtask

  // Reference decode: updates the key model and queues the event the DUT must emit.
  task automatic send_byte(input logic [7:0] b, input bit good);
    logic p;
    p = good ? ~(^b) : (^b);
    if (!good) begin
      exp_q.push_back({1'b1, m_code, m_cext, m_cbrk, m_ks});
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (keys[i] == {m_ext, b}) m_ks[i] = ~m_brk;
      m_code = b; m_cext = m_ext; m_cbrk = m_brk;
      exp_q.push_back({1'b0, b, m_ext, m_brk, m_ks});
      m_ext = 1'b0; m_brk = 1'b0;
    end
    drive_bits({1'b1, p, b, 1'b0}, 11);
    #(2*HALF);
  endtask

  task automatic test_reset();
    checks++;
    if ({key_state, code, code_ext, code_brk, code_valid, frame_err} !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: got ks=%b code=%h ext=%b brk=%b v=%b err=%b, expected all zero",
               key_state, code, code_ext, code_brk, code_valid, frame_err);
    end
  endtask

  task automatic test_make();
    ev_t e, o;
    send_byte(8'h1D, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL make_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL make_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_break();
    ev_t e, o;
    send_byte(8'hF0, 1'b1);
    send_byte(8'h1D, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL break_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL break_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_extended();
    ev_t e, o;
    send_byte(8'hE0, 1'b1); send_byte(8'h75, 1'b1);
    send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h75, 1'b1);
    send_byte(8'h75, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ext_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL ext_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_parity_err();
    ev_t e, o;
    send_byte(8'hE0, 1'b1);
    send_byte(8'h1B, 1'b0);
    send_byte(8'h1B, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL parity_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL parity_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    ev_t e, o;
    bit  found;
    int  delta;
    drive_bits(11'b000_1010_1010, 5);
    exp_q.push_back({1'b1, m_code, m_cext, m_cbrk, m_ks});
    m_ext = 1'b0; m_brk = 1'b0;
    found = 1'b0;
    for (int k = 0; k < TO + 200 && !found; k++) begin
      @(negedge clk);
      if (frame_err) found = 1'b1;
    end
    delta = cyc - last_fall_cyc;
    checks++;
    if (!found || delta < TO || delta > TO + 12) begin
      fails++; $display("FAIL timeout_latency: got found=%b after %0d cycles, expected within %0d..%0d",
                        found, delta, TO, TO + 12);
    end
    repeat (3) @(negedge clk);
    #(2*HALF);
    send_byte(8'h72, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'h72, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL timeout_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL timeout_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    send_byte(8'h1D, 1'b1);
    send_byte(8'h1D, 1'b1);
    send_byte(8'h1D, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL typematic_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL typematic_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    ev_t e, o;
    checks++;
    if (key_state !== m_ks) begin
      fails++; $display("FAIL pre_reset_keys: got %b, expected %b", key_state, m_ks);
    end
    drive_bits(11'b000_0011_1010, 4);
    #5;
    rst_n = 1'b0;
    #20;
    checks++;
    if ({key_state, code, code_ext, code_brk, code_valid, frame_err} !== 16'd0) begin
      fails++;
      $display("FAIL midframe_reset: got ks=%b code=%h ext=%b brk=%b v=%b err=%b, expected all zero",
               key_state, code, code_ext, code_brk, code_valid, frame_err);
    end
    #175;
    rst_n = 1'b1;
    m_ks = 4'd0; m_ext = 1'b0; m_brk = 1'b0; m_code = 8'd0; m_cext = 1'b0; m_cbrk = 1'b0;
    obs_q.delete(); exp_q.delete();
    #(2*HALF);
    send_byte(8'h1D, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL post_reset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL post_reset_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef PS2_GLITCH_FILTER_EN
  task automatic test_glitch();
    ev_t e, o;
    glitch_en = 1'b1;
    send_byte(8'h1B, 1'b1);
    glitch_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++; $display("FAIL glitch_event: got err=%b code=%h ext=%b brk=%b ks=%b, expected err=%b code=%h ext=%b brk=%b ks=%b",
                          o.err, o.code, o.ext, o.brk, o.ks, e.err, e.code, e.ext, e.brk, e.ks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_err();
    test_timeout();
    test_back_to_back();
`ifdef PS2_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
